// File: rtl/led_pio_arbiter_pkg.sv
// Shared types and sizes for the LED PIO arbiter: FSM state encoding and
// PIO bus widths.
package led_pio_arbiter_pkg;
  localparam int NREQ       = 4;
  localparam int PIO_ADDR_W = 2;
  localparam int PIO_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_e;
endpackage

// File: rtl/led_pio_rr_select.sv
// Round-robin priority selector: scans upward from the requester after
// last_grant and returns the first asserted request.
module led_pio_rr_select #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last_grant,
  output logic            any,
  output logic [1:0]      winner
);
  logic       found;
  logic [1:0] idx;

  always_comb begin
    any    = |req;
    winner = last_grant;
    found  = 1'b0;
    idx    = last_grant;
    // 2-bit index arithmetic wraps naturally at 4 requesters
    for (int i = 1; i <= NREQ; i++) begin
      idx = last_grant + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/led_pio_arbiter.sv
// Four-way round-robin arbiter in front of a single LED PIO slave. Each
// transaction runs IDLE -> ISSUE (one chipselect cycle) -> ACK (one-hot strobe).
module led_pio_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NREQ-1:0]                       req,
  input  logic [NREQ-1:0]                       req_write_n,
  input  logic [2*NREQ-1:0]                     req_address,
  input  logic [8*NREQ-1:0]                     req_writedata,
  output logic [NREQ-1:0]                       ack,
  output logic [7:0]                            rdata,
  output logic [1:0]                            grant_id,
  output logic                                  busy,
  output logic                                  pio_chipselect,
  output logic [1:0]                            pio_address,
  output logic                                  pio_write_n,
  output logic [7:0]                            pio_writedata,
  input  logic [7:0]                            pio_readdata,
  output led_pio_arbiter_pkg::state_e           dbg_state
);
  import led_pio_arbiter_pkg::*;

  state_e                  state_q, state_d;
  logic [1:0]              grant_q, last_grant_q;
  logic                    wr_n_q;
  logic [PIO_ADDR_W-1:0]   addr_q;
  logic [PIO_DATA_W-1:0]   wdata_q;
  logic [PIO_DATA_W-1:0]   rdata_q;
  logic                    any_req;
  logic [1:0]              winner;

  led_pio_rr_select #(.NREQ(NREQ)) u_rr_select (
    .req        (req),
    .last_grant (last_grant_q),
    .any        (any_req),
    .winner     (winner)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      wr_n_q       <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      // The whole transaction is captured here so later input changes are ignored
      if (state_q == ST_IDLE && any_req) begin
        grant_q <= winner;
        wr_n_q  <= req_write_n[winner];
        addr_q  <= req_address[{winner, 1'b0} +: PIO_ADDR_W];
        wdata_q <= req_writedata[{winner, 3'b000} +: PIO_DATA_W];
      end
      if (state_q == ST_ISSUE) begin
        rdata_q <= wr_n_q ? pio_readdata : '0;
      end
      if (state_q == ST_ACK) begin
        last_grant_q <= grant_q;
      end
    end
  end

  always_comb begin
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_address    = '0;
    pio_writedata  = '0;
    ack            = '0;
    if (state_q == ST_ISSUE) begin
      pio_chipselect = 1'b1;
      pio_write_n    = wr_n_q;
      pio_address    = addr_q;
      pio_writedata  = wdata_q;
    end
    if (state_q == ST_ACK) begin
      ack = NREQ'(1) << grant_q;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign rdata     = rdata_q;
  assign grant_id  = grant_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_led_pio_arbiter.sv
// Bench for led_pio_arbiter: requester drivers, an LED PIO slave model, and a
// scoreboard fed by a transaction-level round-robin reference model.
module tb_led_pio_arbiter;
  import led_pio_arbiter_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [3:0]  req_write_n;
  logic [7:0]  req_address;
  logic [31:0] req_writedata;
  logic [3:0]  ack;
  logic [7:0]  rdata;
  logic [1:0]  grant_id;
  logic        busy;
  logic        pio_chipselect;
  logic [1:0]  pio_address;
  logic        pio_write_n;
  logic [7:0]  pio_writedata;
  logic [7:0]  pio_readdata;
  state_e      dbg_state;

  led_pio_arbiter #(.NREQ(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_write_n    (req_write_n),
    .req_address    (req_address),
    .req_writedata  (req_writedata),
    .ack            (ack),
    .rdata          (rdata),
    .grant_id       (grant_id),
    .busy           (busy),
    .pio_chipselect (pio_chipselect),
    .pio_address    (pio_address),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- LED PIO slave model ----------------
  logic [7:0] slave_mem [4];
  assign pio_readdata = slave_mem[pio_address];
  always @(posedge clk) begin
    if (pio_chipselect && !pio_write_n) slave_mem[pio_address] <= pio_writedata;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [10:0] exp_pio_q[$];   // {write_n, address, writedata}
  logic [9:0]  exp_ack_q[$];   // {requester id, rdata}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: static request set is served once each, rotating from last+1
  int         model_last = 3;
  logic [7:0] model_mem [4];

  bit   gap_check = 1'b0;
  int   last_ack_cyc = -1;
  logic cs_prev = 1'b0;
  logic [10:0] pe;
  logic [9:0]  ae;

  always @(negedge clk) begin
    if (!reset_n) begin
      cs_prev = 1'b0;
    end else begin
      if (pio_chipselect) begin
        if (exp_pio_q.size() == 0) check("pio_unexpected", 1, 0);
        else begin
          pe = exp_pio_q.pop_front();
          check("pio_write_n", pio_write_n, pe[10]);
          check("pio_address", pio_address, pe[9:8]);
          check("pio_writedata", pio_writedata, pe[7:0]);
        end
      end else begin
        check("pio_idle", {pio_write_n, pio_address, pio_writedata}, {1'b1, 10'b0});
      end
      if (ack != 4'b0) begin
        if (exp_ack_q.size() == 0) check("ack_unexpected", ack, 0);
        else begin
          ae = exp_ack_q.pop_front();
          check("ack_onehot", ack, 4'b0001 << ae[9:8]);
          check("ack_rdata", rdata, ae[7:0]);
          check("ack_grant_id", grant_id, ae[9:8]);
          check("ack_latency", cs_prev, 1);
          if (gap_check && last_ack_cyc >= 0) check("ack_gap", cyc - last_ack_cyc, 3);
          last_ack_cyc = cyc;
        end
      end
      cs_prev = pio_chipselect;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] set, input logic [3:0] wn, input logic [7:0] ad,
                       input logic [31:0] wd, input bit expect_ack);
    int         i;
    int         last;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] rd;
    last = model_last;
    for (int k = 1; k <= 4; k++) begin
      i = (model_last + k) % 4;
      if (set[i]) begin
        a = ad[2*i +: 2];
        d = wd[8*i +: 8];
        exp_pio_q.push_back({wn[i], a, d});
        if (wn[i]) rd = model_mem[a];
        else begin
          rd = 8'h00;
          model_mem[a] = d;
        end
        if (expect_ack) exp_ack_q.push_back({2'(i), rd});
        last = i;
      end
    end
    model_last = last;
    @(negedge clk);
    req_write_n   = wn;
    req_address   = ad;
    req_writedata = wd;
    req           = set;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((req != 4'b0 || busy) && n < limit) begin
      @(negedge clk);
      req = req & ~ack;
      n++;
    end
    if (n >= limit) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_cs(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pio_chipselect && n < limit);
    if (!pio_chipselect) check("wait_cs_timeout", 1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cs"}, pio_chipselect, 0);
    check({tag, "_write_n"}, pio_write_n, 1);
    check({tag, "_pio_addr"}, pio_address, 0);
    check({tag, "_pio_wdata"}, pio_writedata, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = 4'b0;
    model_last = 3;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [7:0]  v;
    logic [3:0]  rset;
    reset_n = 1'b0;
    req = 4'b0;
    req_write_n = 4'hF;
    req_address = 8'h00;
    req_writedata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      v = 8'($urandom);
      slave_mem[k] <= v;
      model_mem[k] = v;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // single write, then a second write and a read of the same register
    issue(4'b0001, 4'b1110, 8'h00, 32'h0000_00A5, 1'b1);
    wait_idle(20);
    issue(4'b1000, 4'b0111, 8'h00, 32'h3C00_0000, 1'b1);
    wait_idle(20);
    issue(4'b0100, 4'b1111, 8'h00, 32'h0000_0000, 1'b1);
    wait_idle(20);

    // all four held after reset: 0,1,2,3 spaced 3 cycles, then 0 again
    pulse_reset();
    gap_check = 1'b1;
    last_ack_cyc = -1;
    issue(4'b1111, 4'($urandom), 8'($urandom), $urandom, 1'b1);
    wait_idle(40);
    gap_check = 1'b0;
    issue(4'b0001, 4'($urandom), 8'($urandom), $urandom, 1'b1);
    wait_idle(20);

    // last_grant=1 with req=1010: 3 then 1
    issue(4'b0010, 4'($urandom), 8'($urandom), $urandom, 1'b1);
    wait_idle(20);
    issue(4'b1010, 4'($urandom), 8'($urandom), $urandom, 1'b1);
    wait_idle(30);

    // reset in the ACK cycle of requester 1: no ack, write stands, 0 first after
    issue(4'b0010, 4'b1101, 8'b0000_1000, 32'h0000_5A00, 1'b0);
    wait_cs(20);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    req = 4'b0;
    model_last = 3;
    @(negedge clk);
    check_reset_outputs("abort");
    reset_n = 1'b1;
    issue(4'b0011, 4'b0011, 8'b0000_0010, $urandom, 1'b1);
    wait_idle(30);

    // requester 0 drops req and changes its data mid-transaction
    issue(4'b0001, 4'b1110, 8'b0000_0001, 32'h0000_0011, 1'b1);
    wait_cs(20);
    req[0] = 1'b0;
    req_writedata[7:0] = 8'h77;
    wait_idle(20);

    // randomized request sets
    for (int b = 0; b < 30; b++) begin
      rset = 4'($urandom_range(1, 15));
      issue(rset, 4'($urandom), 8'($urandom), $urandom, 1'b1);
      wait_idle(40);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("pio_queue_empty", exp_pio_q.size(), 0);
    check("ack_queue_empty", exp_ack_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
